// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared 8:1 result mux. It picks a source,
// steers the mux, captures the word and hands it downstream over valid/ready.
module mux8_rr_arbiter #(
    parameter int DW   = 32,
    parameter int NREQ = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [DW-1:0]   mux_res,
    output logic [2:0]      sel,
    output logic [NREQ-1:0] gnt,
    output logic [DW-1:0]   out_data,
    output logic [2:0]      out_src,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            busy
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        HOLD
    } stateT;

    stateT      state;
    logic [2:0] ptr;
    logic [2:0] winIdx;

    // Scan ptr+1 .. ptr+8 (mod 8); the 3-bit wrap makes the last candidate ptr itself.
    always_comb begin
        logic [2:0] cand;
        logic       found;
        winIdx = ptr;
        cand   = '0;
        found  = 1'b0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = ptr + 3'(k);
            if (!found && req[cand]) begin
                winIdx = cand;
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            sel       <= '0;
            gnt       <= '0;
            out_data  <= '0;
            out_src   <= '0;
            out_valid <= 1'b0;
            ptr       <= 3'd7;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel   <= winIdx;
                        gnt   <= NREQ'(1) << winIdx;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    out_data  <= mux_res;
                    out_src   <= sel;
                    out_valid <= 1'b1;
                    ptr       <= sel;
                    gnt       <= '0;
                    state     <= HOLD;
                end
                HOLD: begin
                    // winIdx already reflects the ptr updated on leaving LOAD
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (|req) begin
                            sel   <= winIdx;
                            gnt   <= NREQ'(1) << winIdx;
                            state <= LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Scoreboard bench for mux8_rr_arbiter: directed scenarios plus random traffic
// compared against a transfer-level reference model.
module tb_mux8_rr_arbiter;

    logic        clk = 1'b0;
    logic        rstN;
    logic [7:0]  req;
    logic [31:0] muxRes;
    logic [2:0]  sel;
    logic [7:0]  gnt;
    logic [31:0] outData;
    logic [2:0]  outSrc;
    logic        outValid;
    logic        outReady;
    logic        busy;

    logic [31:0] srcData [8];
    bit          randData = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          src;
        logic [31:0] data;
    } expT;
    expT sb[$];

    // reference model state
    int   mPhase = 0;   // 0 idle, 1 grant cycle, 2 waiting for acceptance
    int   mPtr   = 7;
    int   mSel   = 0;
    int   mGnt   = 0;
    bit   mValid = 1'b0;

    always #5 clk = ~clk;

    // the shared 8:1 mux is modelled here
    assign muxRes = srcData[sel];

    mux8_rr_arbiter #(.DW(32), .NREQ(8)) dut (
        .clk(clk), .rst_n(rstN), .req(req), .mux_res(muxRes), .sel(sel), .gnt(gnt),
        .out_data(outData), .out_src(outSrc), .out_valid(outValid), .out_ready(outReady),
        .busy(busy)
    );

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int winner(input logic [7:0] r, input int p);
        for (int k = 1; k <= 8; k++) begin
            int idx = (p + k) % 8;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic void modelStep(input logic [7:0] r, input logic rdy, input logic rn);
        int w;
        if (!rn) begin
            mPhase = 0; mSel = 0; mGnt = 0; mValid = 1'b0; mPtr = 7;
            sb.delete();
            return;
        end
        case (mPhase)
            0: if (r != 0) begin
                w = winner(r, mPtr);
                mSel = w; mGnt = 1 << w; mPhase = 1;
            end
            1: begin
                sb.push_back('{src: mSel, data: srcData[mSel]});
                mValid = 1'b1; mPtr = mSel; mGnt = 0; mPhase = 2;
            end
            default: if (rdy) begin
                mValid = 1'b0;
                if (r != 0) begin
                    w = winner(r, mPtr);
                    mSel = w; mGnt = 1 << w; mPhase = 1;
                end else begin
                    mPhase = 0;
                end
            end
        endcase
    endfunction

    task automatic cycle(input logic [7:0] r, input logic rdy, input logic rn);
        req = r; outReady = rdy; rstN = rn;
        if (randData) for (int i = 0; i < 8; i++) srcData[i] = $urandom;
        @(posedge clk);
        modelStep(r, rdy, rn);
        #1;
        check("gnt", 32'(gnt), 32'(mGnt));
        check("sel", 32'(sel), 32'(mSel));
        check("busy", 32'(busy), 32'(mPhase != 0));
        check("out_valid", 32'(outValid), 32'(mValid));
        #1;
    endtask

    // monitor: compares every presented word, pops on acceptance
    initial begin
        forever begin
            @(negedge clk);
            if (outValid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_output: got src %0d data %0h, expected none", outSrc, outData);
                end else begin
                    check("out_data", outData, sb[0].data);
                    check("out_src", 32'(outSrc), 32'(sb[0].src));
                    if (outReady === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [7:0] r;
        for (int i = 0; i < 8; i++) srcData[i] = 32'h1000_0000 + 32'(i);
        srcData[2] = 32'hDEADBEEF;
        cycle(8'h00, 1'b0, 1'b0);
        cycle(8'h00, 1'b0, 1'b0);
        check("reset_out_data", outData, 32'h0);
        check("reset_out_src", 32'(outSrc), 32'h0);

        // single request
        cycle(8'h04, 1'b1, 1'b1);
        repeat (4) cycle(8'h00, 1'b1, 1'b1);

        // all requesting, ready high
        randData = 1'b1;
        repeat (20) cycle(8'hFF, 1'b1, 1'b1);

        // back-pressure with changing mux data
        repeat (8) cycle(8'hFF, 1'b0, 1'b1);
        repeat (3) cycle(8'hFF, 1'b1, 1'b1);
        repeat (3) cycle(8'h00, 1'b1, 1'b1);

        // round-robin wrap: serve 6, then 7 before 0, then 0
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h40, 1'b1, 1'b1);
        repeat (3) cycle(8'h00, 1'b1, 1'b1);
        cycle(8'h81, 1'b1, 1'b1);
        repeat (3) cycle(8'h00, 1'b1, 1'b1);
        cycle(8'h81, 1'b1, 1'b1);
        repeat (3) cycle(8'h00, 1'b1, 1'b1);

        // request dropped during the grant cycle
        cycle(8'h00, 1'b1, 1'b0);
        cycle(8'h08, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        repeat (3) cycle(8'h00, 1'b1, 1'b1);

        // reset while holding an un-accepted word
        repeat (4) cycle(8'hFF, 1'b0, 1'b1);
        cycle(8'hFF, 1'b0, 1'b0);
        repeat (6) cycle(8'hFF, 1'b1, 1'b1);

        // random traffic with occasional resets
        for (int n = 0; n < 3000; n++) begin
            r = 8'($urandom) & 8'($urandom);
            cycle(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 199) != 0));
        end

        // drain
        repeat (6) cycle(8'h00, 1'b1, 1'b1);
        check("scoreboard_empty", 32'(sb.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux8_rr_arbiter.md
Name: mux8_rr_arbiter

Overview:
- Round-robin arbiter and sequencer that shares the team's 8-input, 32-bit result multiplexer between 8 requesters.
- Picks one requester, drives the mux select, and registers the selected 32-bit word into an output holding register.
- Presents that word downstream with a valid/ready handshake.
- Sits between the functional units (sources I0..I7) and the register-file write-back port.

Parameters:
- DW, 32, data width of mux result and output register.
- NREQ, 8, number of requesters. Fixed to 8 to match the 3-bit select; other values unsupported.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst_n, input, 1, synchronous active-low reset.
- req, input, 8, per-source request level; bit i asserted means source i holds valid data on mux input Ii.
- mux_res, input, 32, combinational result returned from the 8:1 mux.
- sel, output, 3, select to the 8:1 mux (S).
- gnt, output, 8, one-hot grant/acknowledge to requesters.
- out_data, output, 32, registered transferred word.
- out_src, output, 3, index of the source that produced out_data.
- out_valid, output, 1, out_data/out_src valid.
- out_ready, input, 1, downstream accepts when high with out_valid.
- busy, output, 1, high whenever state is not IDLE.

Behaviour:
- Reset (rst_n low at a clock edge): state=IDLE, sel=0, gnt=0, out_data=0, out_src=0, out_valid=0, busy=0, round-robin pointer ptr=7. Reset overrides everything, including a pending transfer or an un-accepted out_valid; that data is discarded.
- Arbitration (combinational, evaluated only when the FSM may start a transfer): winner w is the first set bit of req scanning ptr+1, ptr+2, ... modulo 8. After reset, source 0 has highest priority.
- FSM states: IDLE, LOAD, HOLD.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise at the next edge: sel<=w, gnt<=onehot(w), state<=LOAD.
- LOAD (exactly 1 cycle):
  - sel is stable, so mux_res is valid; gnt is high for this single cycle only.
  - At the edge: out_data<=mux_res, out_src<=sel, out_valid<=1, ptr<=sel, gnt<=0, state<=HOLD.
  - Data is captured even if req[sel] dropped during LOAD.
  - out_ready is ignored in LOAD.
- HOLD:
  - out_valid=1; out_data and out_src are held stable until accepted.
  - If out_ready=0, stay in HOLD (back-pressure; sel and ptr unchanged).
  - If out_ready=1 and req==0: out_valid<=0, state<=IDLE.
  - If out_ready=1 and req!=0: out_valid<=0, arbitrate using the updated ptr, sel<=w, gnt<=onehot(w), state<=LOAD. This gives back-to-back transfers.
- Latency: request seen in IDLE -> gnt one cycle later -> out_valid two cycles after the request edge.
- Throughput: one word per 2 cycles with out_ready tied high.
- gnt is a one-cycle pulse. A requester that keeps req high after its gnt is treated as a new request and is served again in round-robin order.
- Fairness: a source holding req continuously is granted within at most 8 transfers.
- busy = (state != IDLE).
- sel holds its last value while in IDLE.
- gnt is never multi-hot; gnt is nonzero only in LOAD.
- No combinational path from req or out_ready to any output. All outputs are registered, except busy, which is decoded from state.

Test Plan:
- Reset then single request: req=8'b0000_0100, mux_res=32'hDEADBEEF -> gnt=8'h04 in cycle 2, out_valid=1 with out_data=32'hDEADBEEF and out_src=2 in cycle 3; with out_ready=1 the FSM returns to IDLE and busy=0.
- All request, out_ready=1, req=8'hFF held -> grant order 0,1,2,...,7,0; one gnt pulse every 2 cycles; out_src matches the order.
- Back-pressure: out_ready=0 for 5 cycles while in HOLD, mux_res changing -> out_data, out_src and sel stable; no gnt pulses; accepted on the first cycle out_ready=1.
- Round-robin wrap: after serving source 6, req=8'b1000_0001 -> source 7 granted before 0; after 7, req=8'b1000_0001 -> source 0 granted.
- Request drop during LOAD: req[3] deasserted in the LOAD cycle -> word still captured, out_src=3, out_valid=1.
- Reset mid-operation: rst_n=0 during HOLD with out_valid=1 -> next cycle out_valid=0, gnt=0, sel=0, state IDLE; next req=8'hFF grants source 0 first.
